// File: rtl/muldiv_if.sv
// muldiv_if: request/writeback bundle between the core and the RV32M multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            wb_write_n;
    modport master (
        output start, funct3, rs1_data, rs2_data, rd_addr,
        input  busy, done, result, rd_out, wb_write_n
    );
    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_addr,
        output busy, done, result, rd_out, wb_write_n
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 34-cycle latency from accept to done.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int IW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        f3;
    logic              neg_a, neg_b, sa, sb, q_bit, ovf;
    logic [XLEN-1:0]   a_mag, b_mag, rem_nx, quo, rem, a_orig, fin;
    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    assign sa = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    assign sb = bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? CALC : IDLE;
            CALC:    state_nx = (cnt == CNT_W'(XLEN-1)) ? SIGN : CALC;
            SIGN:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.busy       = state != IDLE;
        bus.done       = state == DONE;
        bus.wb_write_n = !(state == DONE && bus.rd_out != 5'd0);
    end
    // The accumulator starts cleared: multiplier bits are walked by cnt and product bits
    // shift into the low half; dividend bits enter MSB-first beside the shifting quotient.
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (b_mag[cnt[IW-1:0]] ? {1'b0, a_mag} : '0);
    assign div_shift = {acc[2*XLEN-1:XLEN], a_mag[~cnt[IW-1:0]]};
    assign div_diff  = div_shift - {1'b0, b_mag};
    assign q_bit     = !div_diff[XLEN];
    assign rem_nx    = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign prod      = (neg_a ^ neg_b) ? -acc : acc;
    assign quo       = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem       = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign a_orig    = neg_a ? -a_mag : a_mag;
    assign ovf       = neg_a && neg_b && a_mag == MIN_NEG && b_mag == ONE;
    assign fin = !f3[2]            ? (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                 b_mag == '0       ? (f3[1] ? a_orig : '1) :
                 ovf               ? (f3[1] ? '0 : MIN_NEG) :
                 f3[1]             ? rem : quo;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            f3         <= '0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            a_mag      <= '0;
            b_mag      <= '0;
            acc        <= '0;
            bus.result <= '0;
            bus.rd_out <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    f3         <= bus.funct3;
                    bus.rd_out <= bus.rd_addr;
                    neg_a      <= sa && bus.rs1_data[XLEN-1];
                    neg_b      <= sb && bus.rs2_data[XLEN-1];
                    a_mag      <= (sa && bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
                    b_mag      <= (sb && bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;
                    acc        <= '0;
                    cnt        <= '0;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= f3[2] ? {rem_nx, acc[XLEN-2:0], q_bit} : {mul_sum, acc[XLEN-1:1]};
                end
                SIGN: bus.result <= fin;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed RV32M vectors checked against literals and a cycle-level reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    muldiv_if bus();
    muldiv_unit dut (.clk(clk), .reset(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_op(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        ea = (f inside {3'd0, 3'd1, 3'd2}) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (f inside {3'd0, 3'd1}) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        sa = a;
        sb = b;
        if (f == 3'd0) return p[31:0];
        if (!f[2]) return p[63:32];
        if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
        if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
        case (f)
            3'd4:    return sa / sb;
            3'd5:    return a / b;
            3'd6:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    int          m_left = 0;
    logic [31:0] m_pend = 0, m_res = 0;
    logic [4:0]  m_rd = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_res  <= 0;
            m_rd   <= 0;
        end else if (m_left == 0) begin
            if (bus.start) begin
                m_left <= 34;
                m_pend <= ref_op(bus.funct3, bus.rs1_data, bus.rs2_data);
                m_rd   <= bus.rd_addr;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) m_res <= m_pend;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_left != 0));
        chk("done", 32'(bus.done), 32'(m_left == 1));
        chk("wb_write_n", 32'(bus.wb_write_n), 32'(!(m_left == 1 && m_rd != 0)));
        chk("result", bus.result, m_res);
        chk("rd_out", 32'(bus.rd_out), 32'(m_rd));
    end

    task automatic run_op(string name, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                          logic [4:0] rd, logic [31:0] exp, int p1 = -1, int p2 = -1);
        bit seen = 0;
        int lat = 0;
        @(negedge clk);
        bus.start = 1; bus.funct3 = f; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = rd;
        @(posedge clk); #1;
        bus.start = 0;
        bus.rs1_data = $urandom; bus.rs2_data = $urandom;
        bus.funct3 = 3'($urandom); bus.rd_addr = 5'($urandom);
        for (int k = 1; k <= 40 && !seen; k++) begin
            bus.start = (k == p1 || k == p2);
            @(posedge clk); #1;
            if (bus.done) begin
                seen = 1;
                lat = k + 1;
            end
        end
        bus.start = 0;
        if (!seen) chk({name, " timeout"}, 32'(seen), 32'd1);
        else begin
            chk({name, " latency"}, 32'(lat), 32'd34);
            chk(name, bus.result, exp);
            chk({name, " rd_out"}, 32'(bus.rd_out), 32'(rd));
            chk({name, " wb_write_n"}, 32'(bus.wb_write_n), 32'(rd == 0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.start = 0; bus.funct3 = 0; bus.rs1_data = 0; bus.rs2_data = 0; bus.rd_addr = 0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset rd_out", 32'(bus.rd_out), 32'd0);
        chk("reset wb_write_n", 32'(bus.wb_write_n), 32'd1);
        rst = 0;
        run_op("MUL", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB);
        run_op("MULHU", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE);
        run_op("MULH", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000);
        run_op("MULHSU", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF);
        run_op("DIV", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD);
        run_op("REM", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF);
        run_op("DIVU", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
        run_op("REMU", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2);
        run_op("DIVU by zero", 3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF);
        run_op("REM by zero", 3'd6, 32'd5, 32'd0, 5'd10, 32'd5);
        run_op("DIV overflow", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000);
        run_op("REM overflow", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000);
        run_op("MUL busy starts", 3'd0, 32'd1000, 32'd1000, 5'd13, 32'h000F4240, 5, 20);
        run_op("DIVU rd0", 3'd5, 32'd100, 32'd7, 5'd0, 32'd14);
        @(negedge clk);
        bus.start = 1; bus.funct3 = 3'd0; bus.rs1_data = 32'd5; bus.rs2_data = 32'd6; bus.rd_addr = 5'd9;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (9) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort result", bus.result, 32'd0);
        chk("abort wb_write_n", 32'(bus.wb_write_n), 32'd1);
        @(negedge clk);
        rst = 0;
        run_op("MUL after reset", 3'd0, 32'd3, 32'd4, 5'd7, 32'd12);
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
